ysyx_220053_mdu: RTL

Parametrised iterative multiply/divide unit for the execute stage, the multi-cycle companion of the single-cycle ALU path. Accepts one RV M-extension operation per handshake, including the RV64 word (*W) forms. Iterates one bit per cycle, short-circuits divide-by-zero and signed-overflow cases, and holds its result until writeback accepts it. Replaces the ad-hoc busy/stall pairing with a valid/ready interface on both sides plus a pipeline flush.

---
 rtl/ysyx_220053_mdu_pkg.sv | 17 +
 rtl/ysyx_220053_mdu_sign.sv | 36 +++
 rtl/ysyx_220053_mdu.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ysyx_220053_mdu_pkg.sv
// ysyx_220053_mdu_pkg: op encodings, FSM states and XLEN legality for the iterative MDU
package ysyx_220053_mdu_pkg;
  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_e;

  function automatic bit mdu_xlen_ok(input int xlen);
    return xlen == 32 || xlen == 64;
  endfunction
endpackage

// File: rtl/ysyx_220053_mdu_sign.sv
// ysyx_220053_mdu_sign: operand extension/magnitude/sign decode and final conditional negate
module ysyx_220053_mdu_sign
  import ysyx_220053_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]        op_i,
  input  logic              word_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [XLEN-1:0]   ext_b_o,
  output logic [XLEN-1:0]   abs_a_o,
  output logic [XLEN-1:0]   abs_b_o,
  output logic              neg_a_o,
  output logic              neg_b_o,
  input  logic              neg_i,
  input  logic [2*XLEN-1:0] fix_i,
  output logic [2*XLEN-1:0] fix_o
);
  logic            sa, sb;
  logic [XLEN-1:0] ext_a;

  assign sa = op_i inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  assign sb = op_i inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};

  // word forms see only the low 32 bits, extended according to the operand's signedness
  assign ext_a   = word_i ? (sa ? XLEN'($signed(a_i[31:0])) : XLEN'(a_i[31:0])) : a_i;
  assign ext_b_o = word_i ? (sb ? XLEN'($signed(b_i[31:0])) : XLEN'(b_i[31:0])) : b_i;

  assign neg_a_o = sa && ext_a[XLEN-1];
  assign neg_b_o = sb && ext_b_o[XLEN-1];
  assign abs_a_o = neg_a_o ? -ext_a : ext_a;
  assign abs_b_o = neg_b_o ? -ext_b_o : ext_b_o;

  assign fix_o = neg_i ? -fix_i : fix_i;
endmodule

// File: rtl/ysyx_220053_mdu.sv
// ysyx_220053_mdu: iterative RV M-extension multiply/divide unit, one bit per cycle, valid/ready both sides
module ysyx_220053_mdu
  import ysyx_220053_mdu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int CW = $clog2(XLEN + 1);

  if (!mdu_xlen_ok(XLEN)) begin : g_xlen_chk
    $error("ysyx_220053_mdu: XLEN must be 32 or 64");
  end

  mdu_state_e        state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic              word_q, negq_q, negr_q;
  logic [TAG_W-1:0]  tag_q;
  logic [2*XLEN-1:0] acc_q, opa_q;
  logic [XLEN-1:0]   opb_q, res_q;

  logic              w, div0, ovf, is_rem, neg_a, neg_b, ge, hi, fix_neg;
  logic [XLEN-1:0]   ext_b, abs_a, abs_b, wa, fast_res, min_mag, rem_d, quo_d, fin;
  logic [XLEN:0]     shl, diff;
  logic [2*XLEN-1:0] acc_d, fix_in, fix;
  logic [31:0]       w32;

  ysyx_220053_mdu_sign #(.XLEN(XLEN)) u_sign (
    .op_i    (in_op),
    .word_i  (w),
    .a_i     (in_a),
    .b_i     (in_b),
    .ext_b_o (ext_b),
    .abs_a_o (abs_a),
    .abs_b_o (abs_b),
    .neg_a_o (neg_a),
    .neg_b_o (neg_b),
    .neg_i   (fix_neg),
    .fix_i   (fix_in),
    .fix_o   (fix)
  );

  assign w        = in_word && (XLEN == 64);
  assign min_mag  = w ? XLEN'(1) << 31 : XLEN'(1) << (XLEN - 1);
  assign is_rem   = in_op[2] && in_op[1];
  assign div0     = in_op[2] && ext_b == '0;
  assign ovf      = (in_op == MDU_DIV || in_op == MDU_REM) && neg_a && abs_a == min_mag && ext_b == '1;
  assign wa       = w ? XLEN'($signed(in_a[31:0])) : in_a;
  assign fast_res = is_rem ? (div0 ? wa : '0) : (div0 ? '1 : wa);

  // shift-add step: multiplicand in opa_q moves left, multiplier in opb_q moves right
  assign acc_d = acc_q + (opb_q[0] ? opa_q : '0);

  // restoring step: remainder in acc_q low half, dividend shifts out of opb_q as quotient shifts in
  assign shl   = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
  assign diff  = shl - {1'b0, opa_q[XLEN-1:0]};
  assign ge    = shl >= {1'b0, opa_q[XLEN-1:0]};
  assign rem_d = ge ? diff[XLEN-1:0] : shl[XLEN-1:0];
  assign quo_d = {opb_q[XLEN-2:0], ge};

  assign fix_in  = op_q[2] ? {{XLEN{1'b0}}, op_q[1] ? rem_d : quo_d} : acc_d;
  assign fix_neg = op_q[2] && op_q[1] ? negr_q : negq_q;
  assign hi      = !op_q[2] && op_q[1:0] != 2'd0;
  assign w32     = hi ? fix[63:32] : fix[31:0];
  assign fin     = word_q ? XLEN'($signed(w32)) : hi ? fix[2*XLEN-1:XLEN] : fix[XLEN-1:0];

  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign out_result = res_q;
  assign out_tag    = tag_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      tag_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q   <= in_op;
          word_q <= w;
          tag_q  <= in_tag;
          negq_q <= neg_a ^ neg_b;
          negr_q <= neg_a;
          acc_q  <= '0;
          opa_q  <= {{XLEN{1'b0}}, in_op[2] ? abs_b : abs_a};
          // word dividends are pre-aligned to the top so the divide step always pulls from bit XLEN-1
          opb_q  <= in_op[2] ? (w ? abs_a << (XLEN - 32) : abs_a) : abs_b;
          if (div0 || ovf) begin
            res_q   <= fast_res;
            state_q <= DONE;
          end else begin
            cnt_q   <= w ? CW'(32) : CW'(XLEN);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          acc_q <= op_q[2] ? {{XLEN{1'b0}}, rem_d} : acc_d;
          opa_q <= op_q[2] ? opa_q : opa_q << 1;
          opb_q <= op_q[2] ? quo_d : opb_q >> 1;
          if (cnt_q == CW'(1)) begin
            res_q   <= fin;
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
